// File: rtl/instr_encoder_loader_if.sv
// Source-side bundle and instruction-memory write port of the encoder/loader.
// Handshake: a bundle transfers on a rising clk edge where in_valid and in_ready
// are both high; the source holds every field stable while in_valid=1 and
// in_ready=0, and in_ready never depends combinationally on in_valid.
interface instr_encoder_loader_if #(
  parameter int DEPTH_LOG2 = 8
);
  logic                  start;
  logic                  finish;
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            fmt;
  logic [6:0]            opcode;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [31:0]           imm;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [DEPTH_LOG2:0]   count;
  logic                  full;
  logic                  done;
  logic                  err;
  logic [1:0]            dbg_state;

  modport master (
    output start, finish, in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, full, done, err, dbg_state
  );

  modport slave (
    input  start, finish, in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
    output in_ready, mem_we, mem_addr, mem_wdata, count, full, done, err, dbg_state
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Reassembles decoded RV32I fields into instruction words and writes them
// sequentially into instruction memory, optionally sealing with a NOP.
module instr_encoder_loader #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  instr_encoder_loader_if.slave   bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_MAX  = '1;
  localparam logic [31:0]           NOP_WORD = 32'h0000_0013;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEAL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state;
  logic [DEPTH_LOG2-1:0] ptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  err_q;
  logic                  full_w;
  logic                  accept;
  logic                  fmt_ok;
  logic [31:0]           enc;
  logic [DEPTH_LOG2-1:0] ptr_next;

  assign full_w   = (cnt == CNT_FULL);
  assign fmt_ok   = (bus.fmt <= 3'd5);
  assign accept   = bus.in_valid & bus.in_ready;
  // The pointer stops at the last word instead of wrapping back to 0.
  assign ptr_next = (ptr == PTR_MAX) ? ptr : ptr + 1'b1;

  assign bus.count     = cnt;
  assign bus.full      = full_w;
  assign bus.done      = (state == S_DONE);
  assign bus.err       = err_q;
  assign bus.dbg_state = state;

  // Ready only while loading, not full, and no control pulse competes this cycle.
  always_comb begin
    bus.in_ready = rst_n && ((state == S_IDLE) || (state == S_LOAD)) &&
                   !full_w && !bus.finish && !bus.start;
  end

  // Field packing; out-of-range immediate bits are simply dropped.
  always_comb begin
    enc = '0;
    case (bus.fmt)
      3'd0: enc = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      3'd1: enc = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
      3'd2: enc = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
      3'd3: enc = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                   bus.imm[4:1], bus.imm[11], bus.opcode};
      3'd4: enc = {bus.imm[31:12], bus.rd, bus.opcode};
      3'd5: enc = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                   bus.rd, bus.opcode};
      default: enc = '0;
    endcase
  end

  // Load FSM, pointer/count bookkeeping and the registered memory write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ptr           <= '0;
      cnt           <= '0;
      err_q         <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else if (bus.start) begin
      state      <= S_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      err_q      <= 1'b0;
      bus.mem_we <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        S_IDLE, S_LOAD: begin
          if (bus.finish) begin
            state <= full_w ? S_DONE : S_SEAL;
          end else if (accept) begin
            state <= S_LOAD;
            if (fmt_ok) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= ptr;
              bus.mem_wdata <= enc;
              ptr           <= ptr_next;
              cnt           <= cnt + 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_SEAL: begin
          bus.mem_we    <= 1'b1;
          bus.mem_addr  <= ptr;
          bus.mem_wdata <= NOP_WORD;
          ptr           <= ptr_next;
          cnt           <= cnt + 1'b1;
          state         <= S_DONE;
        end
        default: state <= S_DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed encodings plus randomized loads,
// with a scoreboard of expected memory writes popped by a monitor.
module tb_instr_encoder_loader;
  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;
  localparam int W     = DL + 32;

  logic clk;
  logic rst_n;

  instr_encoder_loader_if #(.DEPTH_LOG2(DL)) bus ();

  instr_encoder_loader #(.DEPTH_LOG2(DL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  // reference model state
  int   m_count;
  logic m_err;
  logic m_done;

  int cyc = 0;
  int last_wr_cyc = -10;
  int prev_wr_cyc = -20;

  // clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoding from the field layout, by shifting and masking.
  function automatic logic [31:0] ref_encode(input int f, input logic [31:0] op,
      input logic [31:0] rd_, input logic [31:0] r1, input logic [31:0] r2,
      input logic [31:0] f3, input logic [31:0] f7, input logic [31:0] im);
    logic [31:0] w;
    w = 32'h0;
    case (f)
      0: w = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rd_ << 7) | op;
      1: w = ((im & 32'hfff) << 20) | (r1 << 15) | (f3 << 12) | (rd_ << 7) | op;
      2: w = (((im >> 5) & 32'h7f) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) |
             ((im & 32'h1f) << 7) | op;
      3: w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3f) << 25) | (r2 << 20) |
             (r1 << 15) | (f3 << 12) | (((im >> 1) & 32'hf) << 8) |
             (((im >> 11) & 1) << 7) | op;
      4: w = (im & 32'hffff_f000) | (rd_ << 7) | op;
      5: w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3ff) << 21) |
             (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hff) << 12) | (rd_ << 7) | op;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // monitor: every write the DUT presents must match the head of the queue
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.mem_we === 1'b1) begin
      prev_wr_cyc = last_wr_cyc;
      last_wr_cyc = cyc;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h, required no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== e) begin
          n_fail++;
          $display("FAIL write: got addr %0d data 0x%08h, required addr %0d data 0x%08h",
                   bus.mem_addr, bus.mem_wdata, e[W-1:32], e[31:0]);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.start = 0; bus.finish = 0; bus.in_valid = 0;
    bus.fmt = 0; bus.opcode = 0; bus.rd = 0; bus.rs1 = 0; bus.rs2 = 0;
    bus.funct3 = 0; bus.funct7 = 0; bus.imm = 0;
  endtask

  // Issue one bundle; called just after a rising edge, returns #1 after the accept edge.
  task automatic send(input int f, input int op, input int rd_, input int r1, input int r2,
                      input int f3, input int f7, input logic [31:0] im,
                      input bit use_gold, input logic [31:0] gold);
    bit got;
    logic [31:0] w;
    got = 0;
    bus.fmt = 3'(f); bus.opcode = 7'(op); bus.rd = 5'(rd_); bus.rs1 = 5'(r1);
    bus.rs2 = 5'(r2); bus.funct3 = 3'(f3); bus.funct7 = 7'(f7); bus.imm = im;
    bus.in_valid = 1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) got = 1;
      @(posedge clk);
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 20 cycles, required 1");
    end else if (f <= 5) begin
      w = use_gold ? gold : ref_encode(f, 32'(op), 32'(rd_), 32'(r1), 32'(r2),
                                       32'(f3), 32'(f7), im);
      exp_q.push_back({DL'(m_count), w});
      m_count++;
    end else begin
      m_err = 1;
    end
    #1;
    bus.in_valid = 0;
  endtask

  task automatic send_rand(input bit allow_bad);
    int f;
    f = allow_bad ? ($urandom_range(0, 7) == 0 ? int'($urandom_range(6, 7))
                                               : int'($urandom_range(0, 5)))
                  : int'($urandom_range(0, 5));
    send(f, $urandom_range(0, 127), $urandom_range(0, 31), $urandom_range(0, 31),
         $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 127),
         $urandom, 1'b0, 32'h0);
  endtask

  task automatic pulse_start();
    bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
    m_count = 0; m_err = 0; m_done = 0;
  endtask

  // finish pulse, then wait until the seal (if any) is written and done is up
  task automatic pulse_finish();
    bus.finish = 1;
    @(posedge clk); #1;
    bus.finish = 0;
    if (!m_done) begin
      if (m_count < DEPTH) begin
        exp_q.push_back({DL'(m_count), 32'h0000_0013});
        m_count++;
      end
      m_done = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_we"},    64'(bus.mem_we),    64'(0));
    check({tag, "_mem_addr"},  64'(bus.mem_addr),  64'(0));
    check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(0));
    check({tag, "_count"},     64'(bus.count),     64'(0));
    check({tag, "_full"},      64'(bus.full),      64'(0));
    check({tag, "_done"},      64'(bus.done),      64'(0));
    check({tag, "_err"},       64'(bus.err),       64'(0));
    check({tag, "_in_ready"},  64'(bus.in_ready),  64'(0));
  endtask

  initial begin
    idle_inputs();
    m_count = 0; m_err = 0; m_done = 0;
    rst_n = 0;
    bus.in_valid = 1;
    #23;
    check_reset_values("reset");
    bus.in_valid = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // R add x3,x1,x2
    send(0, 'h33, 3, 1, 2, 0, 0, 32'h0, 1'b1, 32'h002081B3);
    check("r_count", 64'(bus.count), 64'(1));
    pulse_start();

    // back-to-back I then S
    send(1, 'h13, 1, 0, 0, 0, 0, 32'd5, 1'b1, 32'h00500093);
    send(2, 'h23, 0, 1, 2, 2, 0, 32'd8, 1'b1, 32'h0020A423);
    @(posedge clk); #1;
    check("b2b_consecutive_we", 64'(last_wr_cyc - prev_wr_cyc), 64'(1));
    check("b2b_count", 64'(bus.count), 64'(2));

    // B, J, U
    send(3, 'h63, 0, 0, 0, 0, 0, 32'd8, 1'b1, 32'h00000463);
    send(5, 'h6F, 1, 0, 0, 0, 0, 32'd16, 1'b1, 32'h010000EF);
    send(4, 'h37, 5, 0, 0, 0, 0, 32'h12345000, 1'b1, 32'h123452B7);
    check("bju_count", 64'(bus.count), 64'(m_count));

    // invalid format: no write, sticky err
    send(7, 'h33, 1, 1, 1, 0, 0, 32'h0, 1'b0, 32'h0);
    check("bad_count", 64'(bus.count), 64'(m_count));
    check("bad_err", 64'(bus.err), 64'(1));
    send_rand(1'b0);
    repeat (2) @(posedge clk); #1;
    check("bad_err_sticky", 64'(bus.err), 64'(1));
    pulse_start();
    check("start_err_clr", 64'(bus.err), 64'(0));
    check("start_count_clr", 64'(bus.count), 64'(0));

    // two words then seal
    send_rand(1'b0);
    send_rand(1'b0);
    pulse_finish();
    check("seal_done", 64'(bus.done), 64'(1));
    check("seal_count", 64'(bus.count), 64'(3));
    check("seal_in_ready", 64'(bus.in_ready), 64'(0));

    // randomized loads
    for (int r = 0; r < 6; r++) begin
      int n;
      pulse_start();
      n = $urandom_range(0, DEPTH - 2);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send_rand(1'b1);
      end
      check("rnd_count", 64'(bus.count), 64'(m_count));
      pulse_finish();
      check("rnd_done", 64'(bus.done), 64'(1));
      check("rnd_final_count", 64'(bus.count), 64'(m_count));
      check("rnd_err", 64'(bus.err), 64'(m_err));
    end

    // fill to DEPTH, then finish without a seal
    pulse_start();
    for (int i = 0; i < DEPTH; i++) send_rand(1'b0);
    check("fill_full", 64'(bus.full), 64'(1));
    check("fill_count", 64'(bus.count), 64'(DEPTH));
    bus.in_valid = 1; bus.fmt = 0;
    repeat (3) begin
      @(negedge clk);
      check("fill_in_ready", 64'(bus.in_ready), 64'(0));
    end
    @(posedge clk); #1;
    bus.in_valid = 0;
    pulse_finish();
    check("fill_done", 64'(bus.done), 64'(1));
    check("fill_final_count", 64'(bus.count), 64'(DEPTH));

    // reset in the middle of a load drops the pending write
    pulse_start();
    send_rand(1'b0);
    send_rand(1'b0);
    @(posedge clk); #1;
    send_rand(1'b0);
    rst_n = 0;
    exp_q.delete();
    m_count = 0; m_err = 0; m_done = 0;
    #2;
    check_reset_values("midreset");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    send(0, 'h33, 3, 1, 2, 0, 0, 32'h0, 1'b1, 32'h002081B3);
    check("after_reset_count", 64'(bus.count), 64'(1));

    repeat (4) @(posedge clk); #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 ns, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Packs decoded RV32I instruction fields (opcode, registers, funct3/funct7, immediate, format) back into 32-bit instruction words and writes them sequentially into the instruction memory. It is the write side of the decode stage's field extraction: the decode stage splits words into fields, and this block reassembles them. It sits between the test/boot program source and the instruction memory write port. It can seal a program with a terminating NOP.

## Interface
- DEPTH_LOG2, 8, log2 of instruction memory depth in words (DEPTH = 2**DEPTH_LOG2)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; clears pointer, count, err; returns FSM to IDLE
- in_valid  in  1  field bundle valid
- in_ready  out  1  block can accept a bundle this cycle
- fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J, 6–7 invalid
- opcode  in  7 ; rd  in  5 ; rs1  in  5 ; rs2  in  5 ; funct3  in  3 ; funct7  in  7
- imm  in  32  immediate, byte-offset form (B/J bit 0 ignored)
- finish  in  1  pulse; seal program with NOP 0x00000013
- mem_we  out  1  instruction memory write enable (registered)
- mem_addr  out  DEPTH_LOG2  word address (registered)
- mem_wdata  out  32  encoded word (registered)
- count  out  DEPTH_LOG2+1  words written or pending
- full  out  1  count == DEPTH
- done  out  1  FSM in DONE
- err  out  1  sticky, invalid fmt seen

## Operation
- Encoding:
  - R = {funct7, rs2, rs1, funct3, rd, opcode}
  - I = {imm[11:0], rs1, funct3, rd, opcode}
  - S = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U = {imm[31:12], rd, opcode}
  - J = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Unused imm bits are discarded silently; there is no range check.
- FSM states and transitions:
  - IDLE (count=0) → LOAD on first accept.
  - IDLE or LOAD → SEAL on finish with count<DEPTH.
  - IDLE or LOAD → DONE on finish with full=1.
  - SEAL → DONE after one cycle.
  - DONE holds until start.
- in_ready = 1 only in IDLE or LOAD, with !full, finish=0 and start=0.
- Accept (in_valid & in_ready), valid fmt:
  - register the encoded word, the pointer and mem_we=1 for the next cycle
  - pointer += 1, count += 1
- Accept, invalid fmt: bundle consumed, no write, pointer and count unchanged, err ← 1.
- SEAL: writes 0x00000013 at the pointer; count += 1.
- start has priority over finish and accept. It clears pointer, count and err and forces IDLE. A write already registered still completes on mem_we in that cycle.
- full blocks accept; further words are never written (no wrap-around). The pointer saturates at DEPTH-1 after the last write.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, done=0, err=0, FSM=IDLE.
- in_ready is driven low while rst_n=0.
- Latency: accept at edge N → mem_we=1 with addr/data during cycle N..N+1. Exactly one write pulse per valid accept.
- Back-to-back accepts give a continuous mem_we with consecutive addresses.
- count and full update on the accept edge, not the write edge.
- finish → SEAL next cycle → NOP write visible with mem_we one cycle later → done=1 the cycle after SEAL.
- in_valid held while in_ready=0 is not consumed; the source holds the bundle.
- Reset asserted mid-load clears everything immediately and drops any pending write.

## Test plan
- Reset then R add x3,x1,x2 (funct7=0, rs2=2, rs1=1, f3=0, rd=3, op=0x33) → mem_we one cycle later, addr 0, data 0x002081B3, count=1.
- Back-to-back I addi x1,x0,5 then S sw x2,8(x1) (imm=8, f3=2, op=0x23) → addr 0 = 0x00500093, addr 1 = 0x0020A423, mem_we high two consecutive cycles.
- B beq x0,x0,+8 (op 0x63) → 0x00000463; J jal x1,+16 (op 0x6F) → 0x010000EF; U lui x5,0x12345000 (op 0x37) → 0x123452B7.
- fmt=7 accepted → no mem_we, count unchanged, err=1 sticky; subsequent start → err=0, count=0.
- Fill DEPTH words → full=1, in_ready=0, no write beyond addr DEPTH-1. Then finish → DONE with no NOP write.
- Two words then finish → NOP 0x00000013 at addr 2, count=3, done=1, in_ready=0. Assert rst_n=0 mid-load → all outputs return to reset values.
